// File: rtl/input_conditioner.sv
// input_conditioner
// Front-panel conditioning for NBTN push buttons and an SWW-bit switch bank.
// A free-running divider produces a sample tick; each pin is synchronised,
// sampled on the tick, and accepted only after it has been stable for several
// consecutive ticks. Buttons produce a level and a one-clock event pulse.
// The pulse can fire on the rising edge, the falling edge, either edge, or on
// the rising edge followed by auto-repeat. Switches produce a level plus a
// change strobe. Button 0 events are counted in a wrapping counter.
module input_conditioner #(
  parameter int NBTN     = 4,
  parameter int SWW      = 8,
  parameter int DIV_W    = 17,
  parameter int DB_LEN   = 3,
  parameter int RPT_DLY  = 64,
  parameter int RPT_RATE = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBTN-1:0]  i_btn,
  input  logic [SWW-1:0]   i_sw,
  input  logic [1:0]       i_mode,
  input  logic             i_cnt_clr,
  output logic             o_tick,
  output logic [NBTN-1:0]  o_btn_lvl,
  output logic [NBTN-1:0]  o_btn_pulse,
  output logic [SWW-1:0]   o_sw,
  output logic             o_sw_chg,
  output logic [CNT_W-1:0] o_evt_cnt
);

  // Repeat counter only has to reach RPT_DLY; after the first repeat it is
  // reloaded below that value, so it can never run past it.
  localparam int RC_W = $clog2(RPT_DLY + 1);
  localparam logic [RC_W-1:0] RPT_DLY_C    = RC_W'(RPT_DLY);
  localparam logic [RC_W-1:0] RPT_RELOAD_C = RC_W'(RPT_DLY - RPT_RATE);

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_RPT  = 2'b11
  } mode_e;

  mode_e mode_s;

  // Tick generation
  logic [DIV_W-1:0] div_r;
  logic             tick_d_r;

  // Synchronisers
  logic [NBTN-1:0] btn_s1_r;
  logic [NBTN-1:0] btn_s2_r;
  logic [SWW-1:0]  sw_s1_r;
  logic [SWW-1:0]  sw_s2_r;

  // Button debounce and repeat state
  logic [NBTN-1:0][DB_LEN-1:0] btn_sh_r;
  logic [NBTN-1:0][RC_W-1:0]   rpt_cnt_r;
  logic [NBTN-1:0]             rise_s;
  logic [NBTN-1:0]             fall_s;
  logic [NBTN-1:0]             rpt_hit_s;
  logic [NBTN-1:0]             pulse_nxt_s;
  logic [NBTN-1:0][RC_W-1:0]   rpt_nxt_s;

  // Switch debounce state
  logic [SWW-1:0] sw_cur_r;
  logic [SWW-1:0] sw_prev_r;
  logic           sw_take_s;

  assign mode_s = mode_e'(i_mode);

  // Free-running divider; o_tick is the registered wrap of the divider and
  // tick_d_r marks the cycle in which the freshly shifted samples are judged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r    <= '0;
      o_tick   <= 1'b0;
      tick_d_r <= 1'b0;
    end else begin
      div_r    <= div_r + DIV_W'(1);
      o_tick   <= &div_r;
      tick_d_r <= o_tick;
    end
  end

  // Two-flop synchronisers for every asynchronous pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_r <= '0;
      btn_s2_r <= '0;
      sw_s1_r  <= '0;
      sw_s2_r  <= '0;
    end else begin
      btn_s1_r <= i_btn;
      btn_s2_r <= btn_s1_r;
      sw_s1_r  <= i_sw;
      sw_s2_r  <= sw_s1_r;
    end
  end

  // Per-button edge detection, event pulse selection and repeat counter next
  // state. A detected release takes priority over a repeat on the same tick.
  always_comb begin
    rise_s      = '0;
    fall_s      = '0;
    rpt_hit_s   = '0;
    pulse_nxt_s = '0;
    rpt_nxt_s   = '0;
    for (int i = 0; i < NBTN; i++) begin
      rise_s[i]    = (&btn_sh_r[i]) & ~o_btn_lvl[i];
      fall_s[i]    = ~(|btn_sh_r[i]) & o_btn_lvl[i];
      rpt_hit_s[i] = (mode_s == MODE_RPT) & o_btn_lvl[i] & ~fall_s[i] &
                     ((rpt_cnt_r[i] + RC_W'(1)) == RPT_DLY_C);

      case (mode_s)
        MODE_RISE: pulse_nxt_s[i] = rise_s[i];
        MODE_FALL: pulse_nxt_s[i] = fall_s[i];
        MODE_BOTH: pulse_nxt_s[i] = rise_s[i] | fall_s[i];
        MODE_RPT:  pulse_nxt_s[i] = rise_s[i] | rpt_hit_s[i];
        default:   pulse_nxt_s[i] = 1'b0;
      endcase

      if (rise_s[i] | fall_s[i] | ~o_btn_lvl[i] | (mode_s != MODE_RPT)) begin
        rpt_nxt_s[i] = '0;
      end else if (rpt_hit_s[i]) begin
        rpt_nxt_s[i] = RPT_RELOAD_C;
      end else begin
        rpt_nxt_s[i] = rpt_cnt_r[i] + RC_W'(1);
      end
    end
  end

  // Button sample shift registers, accepted levels, event pulses and repeat
  // counters. Pulses and level changes land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sh_r    <= '0;
      rpt_cnt_r   <= '0;
      o_btn_lvl   <= '0;
      o_btn_pulse <= '0;
    end else begin
      o_btn_pulse <= '0;
      if (o_tick) begin
        for (int i = 0; i < NBTN; i++) begin
          btn_sh_r[i] <= {btn_sh_r[i][DB_LEN-2:0], btn_s2_r[i]};
        end
      end
      if (tick_d_r) begin
        for (int i = 0; i < NBTN; i++) begin
          if (rise_s[i]) begin
            o_btn_lvl[i] <= 1'b1;
          end else if (fall_s[i]) begin
            o_btn_lvl[i] <= 1'b0;
          end
        end
        o_btn_pulse <= pulse_nxt_s;
        rpt_cnt_r   <= rpt_nxt_s;
      end
    end
  end

  // Switch value is accepted once two consecutive tick samples agree and
  // differ from the currently presented value.
  always_comb begin
    sw_take_s = (sw_cur_r == sw_prev_r) && (sw_cur_r != o_sw);
  end

  // Switch sample history, debounced value and change strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_cur_r  <= '0;
      sw_prev_r <= '0;
      o_sw      <= '0;
      o_sw_chg  <= 1'b0;
    end else begin
      o_sw_chg <= 1'b0;
      if (o_tick) begin
        sw_prev_r <= sw_cur_r;
        sw_cur_r  <= sw_s2_r;
      end
      if (tick_d_r && sw_take_s) begin
        o_sw     <= sw_cur_r;
        o_sw_chg <= 1'b1;
      end
    end
  end

  // Button 0 event counter; a clear wins over a coincident event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_evt_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_evt_cnt <= '0;
    end else if (o_btn_pulse[0]) begin
      o_evt_cnt <= o_evt_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a short tick period.
module tb_input_conditioner;

  localparam int NBTN     = 4;
  localparam int SWW      = 8;
  localparam int DIV_W    = 4;
  localparam int DB_LEN   = 3;
  localparam int RPT_DLY  = 4;
  localparam int RPT_RATE = 2;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NBTN-1:0]  i_btn = '0;
  logic [SWW-1:0]   i_sw = '0;
  logic [1:0]       i_mode = 2'b00;
  logic             i_cnt_clr = 1'b0;
  logic             o_tick;
  logic [NBTN-1:0]  o_btn_lvl;
  logic [NBTN-1:0]  o_btn_pulse;
  logic [SWW-1:0]   o_sw;
  logic             o_sw_chg;
  logic [CNT_W-1:0] o_evt_cnt;

  int checks = 0;
  int errors = 0;
  int pcnt [NBTN];
  int swchg_cnt = 0;
  int base;
  int base0;
  int base3;
  int swbase;
  int d;
  bit found;
  bit seen255;
  logic t_prev1;
  logic t_prev2;
  logic exp_p;

  input_conditioner #(
    .NBTN(NBTN), .SWW(SWW), .DIV_W(DIV_W), .DB_LEN(DB_LEN),
    .RPT_DLY(RPT_DLY), .RPT_RATE(RPT_RATE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn), .i_sw(i_sw), .i_mode(i_mode),
    .i_cnt_clr(i_cnt_clr), .o_tick(o_tick), .o_btn_lvl(o_btn_lvl),
    .o_btn_pulse(o_btn_pulse), .o_sw(o_sw), .o_sw_chg(o_sw_chg),
    .o_evt_cnt(o_evt_cnt)
  );

  always #5 clk = ~clk;

  // Pulse and strobe counters, sampled on the inactive edge.
  always @(negedge clk) begin
    for (int i = 0; i < NBTN; i++) begin
      if (o_btn_pulse[i]) pcnt[i] = pcnt[i] + 1;
    end
    if (o_sw_chg) swchg_cnt = swchg_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge at which o_tick is high (bounded).
  task automatic to_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_tick && n < 40);
    chk("tick_wait", o_tick, 1);
  endtask

  // Advance to the cycle right after the tick_d cycle, where new levels and
  // pulses are first visible.
  task automatic wait_tick();
    to_tick();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) wait_tick();
  endtask

  initial begin
    for (int i = 0; i < NBTN; i++) pcnt[i] = 0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_tick", o_tick, 0);
    chk("rst_lvl", o_btn_lvl, 0);
    chk("rst_pulse", o_btn_pulse, 0);
    chk("rst_sw", o_sw, 0);
    chk("rst_swchg", o_sw_chg, 0);
    chk("rst_cnt", o_evt_cnt, 0);
    rst = 1'b0;

    // ---- tick timing: high only in cycles 16, 32, 48 ----
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      chk($sformatf("tick_c%0d", c), o_tick, (c % 16 == 0) ? 1 : 0);
    end
    chk("idle_lvl", o_btn_lvl, 0);
    chk("idle_cnt", o_evt_cnt, 0);

    // ---- bouncing btn0, mode 00 ----
    i_mode = 2'b00;
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) i_btn[0] = ~i_btn[0];
      @(negedge clk);
    end
    i_btn[0] = 1'b1;
    t_prev1 = 1'b0;
    t_prev2 = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (o_btn_lvl[0]) begin
        found = 1'b1;
        break;
      end
      t_prev2 = t_prev1;
      t_prev1 = o_tick;
    end
    chk("b0_lvl_rise", o_btn_lvl[0], 1);
    chk("b0_pulse_with_lvl", o_btn_pulse[0], 1);
    chk("b0_tickd_align", t_prev2, 1);
    @(negedge clk);
    chk("b0_pulse_one_clk", o_btn_pulse[0], 0);
    wait_ticks(4);
    @(negedge clk);
    chk("b0_single_pulse", pcnt[0], 1);
    chk("b0_cnt", o_evt_cnt, 1);
    i_btn[0] = 1'b0;
    wait_ticks(5);
    @(negedge clk);
    chk("b0_release_lvl", o_btn_lvl[0], 0);
    chk("b0_no_fall_pulse", pcnt[0], 1);

    // ---- btn2 press/release, mode 01 then 10 ----
    i_mode = 2'b01;
    base = pcnt[2];
    i_btn[2] = 1'b1;
    wait_ticks(5);
    chk("b2_m01_lvl_hi", o_btn_lvl[2], 1);
    i_btn[2] = 1'b0;
    wait_ticks(5);
    @(negedge clk);
    chk("b2_m01_lvl_lo", o_btn_lvl[2], 0);
    chk("b2_m01_pulses", pcnt[2] - base, 1);
    i_mode = 2'b10;
    base = pcnt[2];
    i_btn[2] = 1'b1;
    wait_ticks(5);
    i_btn[2] = 1'b0;
    wait_ticks(5);
    @(negedge clk);
    chk("b2_m10_pulses", pcnt[2] - base, 2);
    chk("b2_cnt_untouched", o_evt_cnt, 1);

    // ---- btn1 auto-repeat, mode 11 ----
    i_mode = 2'b11;
    base = pcnt[1];
    i_btn[1] = 1'b1;
    for (int n = 0; n < 8; n++) begin
      wait_tick();
      if (o_btn_lvl[1]) break;
    end
    chk("rpt_T0_lvl", o_btn_lvl[1], 1);
    chk("rpt_T0_pulse", o_btn_pulse[1], 1);
    for (int j = 1; j <= 20; j++) begin
      wait_tick();
      exp_p = (j >= 4 && j <= 16 && (j % 2) == 0) ? 1'b1 : 1'b0;
      chk($sformatf("rpt_T0+%0d", j), o_btn_pulse[1], exp_p);
      if (j == 16) chk("rpt_lvl_T0+16", o_btn_lvl[1], 1);
      if (j == 17) chk("rpt_lvl_T0+17", o_btn_lvl[1], 0);
      if (j == 14) i_btn[1] = 1'b0;
    end
    @(negedge clk);
    chk("rpt_total", pcnt[1] - base, 8);

    // ---- event counter wrap using btn0 auto-repeat ----
    i_cnt_clr = 1'b1;
    @(negedge clk);
    i_cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr", o_evt_cnt, 0);
    base = pcnt[0];
    seen255 = 1'b0;
    i_btn[0] = 1'b1;
    for (int n = 0; n < 700; n++) begin
      wait_tick();
      @(negedge clk);
      d = pcnt[0] - base;
      if (d == 255 && !seen255) begin
        seen255 = 1'b1;
        chk("cnt_255", o_evt_cnt, 255);
      end
      if (d >= 256) break;
    end
    i_mode = 2'b00;
    chk("wrap_pulses", pcnt[0] - base, 256);
    chk("cnt_wrap", o_evt_cnt, 0);
    wait_ticks(3);
    @(negedge clk);
    chk("wrap_stop", pcnt[0] - base, 256);

    // ---- clear coincident with a pulse ----
    i_btn[0] = 1'b0;
    wait_ticks(5);
    i_btn[0] = 1'b1;
    for (int n = 0; n < 8; n++) begin
      wait_tick();
      if (o_btn_pulse[0]) break;
    end
    @(negedge clk);
    chk("pre_clr_cnt", o_evt_cnt, 1);
    i_btn[0] = 1'b0;
    wait_ticks(5);
    i_btn[0] = 1'b1;
    for (int n = 0; n < 8; n++) begin
      wait_tick();
      if (o_btn_pulse[0]) break;
    end
    chk("clr_pulse_seen", o_btn_pulse[0], 1);
    i_cnt_clr = 1'b1;
    @(negedge clk);
    i_cnt_clr = 1'b0;
    chk("clr_priority", o_evt_cnt, 0);
    @(negedge clk);
    chk("clr_hold", o_evt_cnt, 0);

    // ---- asynchronous reset during auto-repeat ----
    i_mode = 2'b11;
    i_btn[3] = 1'b1;
    for (int n = 0; n < 12; n++) begin
      wait_tick();
      if (o_btn_pulse[3] && o_btn_lvl[3] && o_evt_cnt != 0) break;
    end
    chk("mid_rpt_pulse", o_btn_pulse[3], 1);
    chk("mid_rpt_lvl", o_btn_lvl, 4'b1001);
    #2 rst = 1'b1;
    #1;
    chk("arst_pulse", o_btn_pulse, 0);
    chk("arst_lvl", o_btn_lvl, 0);
    chk("arst_cnt", o_evt_cnt, 0);
    chk("arst_tick", o_tick, 0);
    chk("arst_sw", o_sw, 0);
    repeat (2) @(negedge clk);
    chk("arst_hold_pulse", o_btn_pulse, 0);
    rst = 1'b0;
    i_sw = 8'hA5;
    swbase = swchg_cnt;
    base0 = pcnt[0];
    base3 = pcnt[3];
    wait_tick();
    chk("rel_t1_pulse", o_btn_pulse, 0);
    chk("rel_t1_lvl", o_btn_lvl, 0);
    wait_tick();
    chk("rel_t2_pulse", o_btn_pulse, 0);
    chk("rel_t2_lvl", o_btn_lvl, 0);
    wait_tick();
    chk("rel_t3_pulse", o_btn_pulse, 4'b1001);
    chk("rel_t3_lvl", o_btn_lvl, 4'b1001);
    i_mode = 2'b00;
    wait_ticks(3);
    @(negedge clk);
    chk("rel_b3_once", pcnt[3] - base3, 1);
    chk("rel_b0_once", pcnt[0] - base0, 1);
    chk("rel_cnt", o_evt_cnt, 1);
    chk("sw_value", o_sw, 8'hA5);
    chk("sw_chg_once", swchg_cnt - swbase, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
